// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, byte-enable
// constants and default geometry.
package dm_pkg;

  localparam int unsigned DM_AW = 12;
  localparam int unsigned DM_DW = 32;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWrite  = 2'd2
  } dm_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant and a
// last-grant pointer register that advances whenever en_i accepts a grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  // On contention the port that was not granted last wins.
  always_comb begin
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
    last_d = last_q;
    if (en_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates CPU (port 0) and DMA (port 1) access to a single-port data memory,
// with read-modify-write for partial stores. Define DM_TRACE_EN to print stores.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned AW = DM_AW,
  parameter int unsigned DW = DM_DW
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_be_i,
  input  logic [31:0]     m0_addr_i,
  input  logic [DW-1:0]   m0_wdata_i,
  input  logic [31:0]     m0_pc_i,
  output logic            m0_gnt_o,
  output logic            m0_done_o,
  output logic [DW-1:0]   m0_rdata_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_be_i,
  input  logic [31:0]     m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  input  logic [31:0]     m1_pc_i,
  output logic            m1_gnt_o,
  output logic            m1_done_o,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_din_o,
  input  logic [DW-1:0]   mem_dout_i,
  output logic [31:0]     mem_pc_o
);

  dm_state_e       state_q, state_d;
  logic            port_q, port_d;
  logic            we_q, we_d;
  logic [DW/8-1:0] be_q, be_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic [31:0]     pc_q, pc_d;
  logic [DW-1:0]   merge_q, merge_d;
  logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      arb_gnt;
  logic            arb_en;
  logic            win;
  logic            partial;

  logic unused_addr;
  assign unused_addr = ^{m0_addr_i[31:AW+2], m0_addr_i[1:0], m1_addr_i[31:AW+2], m1_addr_i[1:0]};

  rr_arb2 u_rr_arb2 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   ({m1_req_i, m0_req_i}),
    .en_i    (arb_en),
    .gnt_o   (arb_gnt)
  );

  assign win     = arb_gnt[1];
  assign partial = we_q && (be_q != BE_FULL) && (be_q != BE_NONE);

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    din_d    = din_q;
    pc_d     = pc_q;
    merge_d  = merge_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    arb_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m0_req_i || m1_req_i) begin
          arb_en  = 1'b1;
          port_d  = win;
          we_d    = win ? m1_we_i : m0_we_i;
          be_d    = win ? m1_be_i : m0_be_i;
          addr_d  = win ? m1_addr_i[AW+1:2] : m0_addr_i[AW+1:2];
          din_d   = win ? m1_wdata_i : m0_wdata_i;
          pc_d    = win ? m1_pc_i : m0_pc_i;
          gnt_d   = arb_gnt;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (partial) begin
          // din_q still holds the store data here; replace only enabled lanes.
          merge_d = mem_dout_i;
          for (int i = 0; i < int'(DW / 8); i++) begin
            if (be_q[i]) merge_d[8*i +: 8] = din_q[8*i +: 8];
          end
          din_d   = merge_d;
          state_d = StWrite;
        end else begin
          done_d[port_q] = 1'b1;
          if (!we_q) begin
            if (port_q) rdata1_d = mem_dout_i;
            else        rdata0_d = mem_dout_i;
          end
          state_d = StIdle;
        end
      end
      StWrite: begin
        done_d[port_q] = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      pc_q     <= '0;
      merge_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      pc_q     <= pc_d;
      merge_q  <= merge_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
    end
  end

  // Reset gating keeps an aborted access from writing in the reset cycle.
  assign mem_we_o   = !reset_i && ((state_q == StWrite) ||
                      ((state_q == StAccess) && we_q && (be_q == BE_FULL)));
  assign mem_addr_o = addr_q;
  assign mem_din_o  = din_q;
  assign mem_pc_o   = pc_q;
  assign m0_gnt_o   = gnt_q[0];
  assign m1_gnt_o   = gnt_q[1];
  assign m0_done_o  = done_q[0];
  assign m1_done_o  = done_q[1];
  assign m0_rdata_o = rdata0_q;
  assign m1_rdata_o = rdata1_q;

`ifdef DM_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (mem_we_o) begin
      $display("@%08h: *%08h <= %08h", mem_pc_o, {{(30 - AW){1'b0}}, mem_addr_o, 2'b00},
               mem_din_o);
    end
  end
`else
  // Store tracing compiled out.
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural 4096-word memory.
module tb_dm_arbiter;

  logic        clk, reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata, m1_pc;
  logic        m0_gnt, m0_done, m1_gnt, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_din, mem_dout, mem_pc;

  logic [31:0] mem [4096];
  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_data;
  int          we_cnt;
  int          we_base;
  int          n_cmp, n_err;
  logic [1:0]  exp_gnt [6];

  dm_arbiter dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .m0_req_i   (m0_req),
    .m0_we_i    (m0_we),
    .m0_be_i    (m0_be),
    .m0_addr_i  (m0_addr),
    .m0_wdata_i (m0_wdata),
    .m0_pc_i    (m0_pc),
    .m0_gnt_o   (m0_gnt),
    .m0_done_o  (m0_done),
    .m0_rdata_o (m0_rdata),
    .m1_req_i   (m1_req),
    .m1_we_i    (m1_we),
    .m1_be_i    (m1_be),
    .m1_addr_i  (m1_addr),
    .m1_wdata_i (m1_wdata),
    .m1_pc_i    (m1_pc),
    .m1_gnt_o   (m1_gnt),
    .m1_done_o  (m1_done),
    .m1_rdata_o (m1_rdata),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_din_o  (mem_din),
    .mem_dout_i (mem_dout),
    .mem_pc_o   (mem_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_din;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    step();
    pl_en   = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; we_cnt = 0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0; m0_pc = 0;
    m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0; m1_pc = 0;
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
    exp_gnt[3] = 2'b10; exp_gnt[4] = 2'b01; exp_gnt[5] = 2'b10;
    step(); step();
    reset = 1'b0;

    // Reset state
    check("rst_gnt",   {m1_gnt, m0_gnt}, 2'b00);
    check("rst_done",  {m1_done, m0_done}, 2'b00);
    check("rst_we",    mem_we, 1'b0);
    check("rst_addr",  mem_addr, 12'h000);
    check("rst_din",   mem_din, 32'h0);
    check("rst_pc",    mem_pc, 32'h0);
    check("rst_rdata", {m1_rdata, m0_rdata}, 64'h0);

    // Full store from port 0
    we_base = we_cnt;
    m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    m0_pc = 32'h3000;
    step();
    check("full_gnt",  {m1_gnt, m0_gnt}, 2'b01);
    check("full_we",   mem_we, 1'b1);
    check("full_addr", mem_addr, 12'h004);
    check("full_din",  mem_din, 32'hDEADBEEF);
    check("full_pc",   mem_pc, 32'h3000);
    m0_req = 0;
    step();
    check("full_done", {m1_done, m0_done}, 2'b01);
    check("full_we_off", mem_we, 1'b0);
    check("full_mem",  mem[4], 32'hDEADBEEF);
    check("full_wecnt", we_cnt - we_base, 1);

    // Partial store from port 1 with junk in the ignored address bits
    preload(12'h004, 32'h11223344);
    we_base = we_cnt;
    m1_req = 1; m1_we = 1; m1_be = 4'b0010; m1_addr = 32'hFFFF0011; m1_wdata = 32'h0000AA00;
    m1_pc = 32'h2000;
    step();
    check("part_gnt",  {m1_gnt, m0_gnt}, 2'b10);
    check("part_we_acc", mem_we, 1'b0);
    check("part_addr", mem_addr, 12'h004);
    check("part_pc",   mem_pc, 32'h2000);
    m1_req = 0;
    step();
    check("part_we_wr", mem_we, 1'b1);
    check("part_din",  mem_din, 32'h1122AA44);
    check("part_early_done", {m1_done, m0_done}, 2'b00);
    step();
    check("part_done", {m1_done, m0_done}, 2'b10);
    check("part_mem",  mem[4], 32'h1122AA44);
    check("part_wecnt", we_cnt - we_base, 1);
    check("part_hold_addr", mem_addr, 12'h004);

    // Simultaneous loads after reset: port 0 first, port 1 next IDLE
    preload(12'h008, 32'hA5A50001);
    preload(12'h009, 32'h5A5A0002);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m0_req = 1; m0_we = 0; m0_be = 4'h0; m0_addr = 32'h20;
    m1_req = 1; m1_we = 0; m1_be = 4'h0; m1_addr = 32'h24;
    step();
    check("ld_gnt0",   {m1_gnt, m0_gnt}, 2'b01);
    check("ld_addr0",  mem_addr, 12'h008);
    m0_req = 0;
    step();
    check("ld_done0",  {m1_done, m0_done}, 2'b01);
    check("ld_rdata0", m0_rdata, 32'hA5A50001);
    step();
    check("ld_gnt1",   {m1_gnt, m0_gnt}, 2'b10);
    check("ld_addr1",  mem_addr, 12'h009);
    m1_req = 0;
    step();
    check("ld_done1",  {m1_done, m0_done}, 2'b10);
    check("ld_rdata1", m1_rdata, 32'h5A5A0002);
    check("ld_rdata0_hold", m0_rdata, 32'hA5A50001);

    // Continuous contention: grants alternate
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_gnt", {m1_gnt, m0_gnt}, exp_gnt[i]);
      if (i == 5) begin
        m0_req = 0; m1_req = 0;
      end
      step();
    end

    // Reset during WRITE of a partial store aborts it
    preload(12'h00C, 32'hCAFEF00D);
    we_base = we_cnt;
    m0_req = 1; m0_we = 1; m0_be = 4'b0001; m0_addr = 32'h30; m0_wdata = 32'h000000EE;
    step();
    check("abort_gnt", {m1_gnt, m0_gnt}, 2'b01);
    m0_req = 0;
    step();
    reset = 1'b1;
    #1;
    check("abort_we",  mem_we, 1'b0);
    step();
    reset = 1'b0;
    check("abort_done", {m1_done, m0_done}, 2'b00);
    check("abort_mem", mem[12], 32'hCAFEF00D);
    check("abort_wecnt", we_cnt - we_base, 0);
    m1_req = 1; m1_we = 0; m1_addr = 32'h30;
    step();
    check("abort_idle_gnt", {m1_gnt, m0_gnt}, 2'b10);
    check("abort_no_done", {m1_done, m0_done}, 2'b00);
    m1_req = 0;
    step();
    check("abort_rd_done", {m1_done, m0_done}, 2'b10);
    check("abort_rd_data", m1_rdata, 32'hCAFEF00D);

    // Store with no byte enables: done but no write
    we_base = we_cnt;
    m0_req = 1; m0_we = 1; m0_be = 4'h0; m0_addr = 32'h30; m0_wdata = 32'hFFFFFFFF;
    step();
    check("be0_gnt",   {m1_gnt, m0_gnt}, 2'b01);
    check("be0_we_acc", mem_we, 1'b0);
    m0_req = 0;
    step();
    check("be0_done",  {m1_done, m0_done}, 2'b01);
    check("be0_we",    mem_we, 1'b0);
    check("be0_wecnt", we_cnt - we_base, 0);
    check("be0_mem",   mem[12], 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
